// File: rtl/seq_detect_param_if.sv
// Bundle of the data, load and result signals of the sequence detector.
// Clock and reset stay outside the bundle as plain ports.
interface seq_detect_param_if #(
   parameter int unsigned PAT_W = 3,
   parameter int unsigned CNT_W = 8
);
   logic             seq_valid_in;
   logic             seq_in;
   logic             load_in;
   logic [PAT_W-1:0] pattern_in;
   logic             overlap_in;
   logic             detected_out;
   logic [CNT_W-1:0] match_count_out;
   logic             count_sat_out;

   modport master (
      output seq_valid_in, seq_in, load_in, pattern_in, overlap_in,
      input  detected_out, match_count_out, count_sat_out
   );

   modport slave (
      input  seq_valid_in, seq_in, load_in, pattern_in, overlap_in,
      output detected_out, match_count_out, count_sat_out
   );
endinterface

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern and overlap mode.
// Moore-style registered match flag plus a saturating match counter.
module seq_detect_param #(
   parameter int unsigned      PAT_W         = 3,
   parameter int unsigned      CNT_W         = 8,
   parameter logic [PAT_W-1:0] RESET_PATTERN = 3'b110,
   parameter logic             RESET_OVERLAP = 1'b1
) (
   input  logic               clk_in,
   input  logic               reset_in,
   seq_detect_param_if.slave  bus
);

   localparam int unsigned      FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   typedef enum logic {HUNT, HIT} state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pattern_q, pattern_d;
   logic               overlap_q, overlap_d;
   logic [PAT_W-2:0]   hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               sat_q, sat_d;

   logic               accept;
   logic               match;
   logic [PAT_W-1:0]   window;

   // Next-state logic: load beats an accepted bit; HIT lasts only while matches keep coming.
   always_comb begin
      pattern_d = pattern_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      count_d   = count_q;

      accept = bus.seq_valid_in & ~bus.load_in;
      window = {hist_q, bus.seq_in};
      match  = accept && (fill_q == FILL_MAX) && (window == pattern_q);

      if (bus.load_in) begin
         pattern_d = bus.pattern_in;
         overlap_d = bus.overlap_in;
         hist_d    = '0;
         fill_d    = '0;
         count_d   = '0;
      end else if (accept) begin
         hist_d = window[PAT_W-2:0];
         if (match && !overlap_q) begin
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FILL_W'(1);
         end
         if (match && !sat_q) begin
            count_d = count_q + CNT_W'(1);
         end
      end

      sat_d   = &count_d;
      state_d = match ? HIT : HUNT;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q   <= HUNT;
         pattern_q <= RESET_PATTERN;
         overlap_q <= RESET_OVERLAP;
         hist_q    <= '0;
         fill_q    <= '0;
         count_q   <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         overlap_q <= overlap_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         count_q   <= count_d;
         sat_q     <= sat_d;
      end
   end

   assign bus.detected_out    = (state_q == HIT);
   assign bus.match_count_out = count_q;
   assign bus.count_sat_out   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: the driver pushes the expected
// post-edge outputs from a bit-queue reference model; a monitor pops and compares.
module tb_seq_detect_param;

   localparam int unsigned PAT_W = 3;
   localparam int unsigned CNT_W = 8;
   localparam int          CMAX  = 255;

   typedef struct packed {
      logic       det;
      logic [7:0] cnt;
      logic       sat;
   } exp_t;

   logic clk = 1'b0;
   logic reset_in;

   seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

   seq_detect_param #(
      .PAT_W        (PAT_W),
      .CNT_W        (CNT_W),
      .RESET_PATTERN(3'b110),
      .RESET_OVERLAP(1'b1)
   ) dut (
      .clk_in  (clk),
      .reset_in(reset_in),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Reference model: last accepted bits since the last restart, oldest first.
   logic [2:0] m_pat;
   bit         m_ovl;
   bit         m_hist[$];
   int         m_cnt;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_pat = 3'b110;
      m_ovl = 1'b1;
      m_hist.delete();
      m_cnt = 0;
   endtask

   task automatic model_edge(input bit v, input bit b, input bit ld,
                             input logic [2:0] p, input bit o);
      bit   hit;
      int   w;
      exp_t e;
      hit = 1'b0;
      if (ld) begin
         m_pat = p;
         m_ovl = o;
         m_hist.delete();
         m_cnt = 0;
      end else if (v) begin
         if (m_hist.size() == PAT_W - 1) begin
            w = 0;
            foreach (m_hist[i]) w = w * 2 + int'(m_hist[i]);
            w   = w * 2 + int'(b);
            hit = (w == int'(m_pat));
         end
         m_hist.push_back(b);
         if (m_hist.size() > PAT_W - 1) void'(m_hist.pop_front());
         if (hit) begin
            if (m_cnt < CMAX) m_cnt++;
            if (!m_ovl) m_hist.delete();
         end
      end
      e.det = hit;
      e.cnt = 8'(m_cnt);
      e.sat = (m_cnt == CMAX);
      exp_q.push_back(e);
   endtask

   // One clock edge of stimulus; also releases a held reset between edges.
   task automatic step(input bit v, input bit b, input bit ld,
                       input logic [2:0] p, input bit o);
      @(posedge clk);
      #2;
      if (!reset_in) reset_in = 1'b1;
      bus.seq_valid_in = v;
      bus.seq_in       = b;
      bus.load_in      = ld;
      bus.pattern_in   = p;
      bus.overlap_in   = o;
      model_edge(v, b, ld, p, o);
   endtask

   task automatic bit_in(input bit b);
      step(1'b1, b, 1'b0, 3'b000, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
   endtask

   task automatic load(input logic [2:0] p, input bit o);
      step(1'b0, 1'b0, 1'b1, p, o);
   endtask

   // Asserts reset between edges with junk inputs; it is released by the next step.
   task automatic pulse_reset();
      exp_t e;
      @(posedge clk);
      #2;
      reset_in         = 1'b0;
      bus.seq_valid_in = 1'b1;
      bus.seq_in       = 1'b1;
      bus.load_in      = 1'b1;
      bus.pattern_in   = 3'b111;
      bus.overlap_in   = 1'b0;
      model_reset();
      #1;
      check("async_rst_det", int'(bus.detected_out), 0);
      check("async_rst_cnt", int'(bus.match_count_out), 0);
      check("async_rst_sat", int'(bus.count_sat_out), 0);
      e = '0;
      exp_q.push_back(e);
   endtask

   // Monitor: after every edge compare whatever expectation the driver queued.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("detected", int'(bus.detected_out), int'(e.det));
            check("count", int'(bus.match_count_out), int'(e.cnt));
            check("count_sat", int'(bus.count_sat_out), int'(e.sat));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_in         = 1'b0;
      bus.seq_valid_in = 1'b0;
      bus.seq_in       = 1'b0;
      bus.load_in      = 1'b0;
      bus.pattern_in   = '0;
      bus.overlap_in   = 1'b0;
      model_reset();
      #3;
      check("reset_det", int'(bus.detected_out), 0);
      check("reset_cnt", int'(bus.match_count_out), 0);
      check("reset_sat", int'(bus.count_sat_out), 0);
      @(posedge clk);
      #3;
      reset_in = 1'b1;

      // Default pattern 110, overlapping.
      bit_in(1); bit_in(1); bit_in(0); idle(2);

      // 101 overlapping, then non-overlapping.
      load(3'b101, 1'b1);
      bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1); idle(2);
      load(3'b101, 1'b0);
      bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1); idle(2);

      // Gap of invalid cycles inside a match.
      load(3'b110, 1'b1);
      bit_in(1); idle(3); bit_in(1); bit_in(0); idle(2);

      // Mid-stream reset drops partial history.
      bit_in(1); bit_in(1);
      pulse_reset();
      bit_in(0); idle(2);

      // Reset while a detection is pending.
      bit_in(1); bit_in(1); bit_in(0);
      pulse_reset();
      idle(2);

      // Load wins over a valid bit on the same edge.
      bit_in(1); bit_in(1);
      step(1'b1, 1'b0, 1'b1, 3'b110, 1'b1);
      bit_in(1); bit_in(1); bit_in(0); idle(2);

      // Counter saturation with an all-ones pattern.
      load(3'b111, 1'b1);
      for (int i = 0; i < 262; i++) bit_in(1);
      idle(2);
      load(3'b110, 1'b1);
      idle(1);

      // Randomized traffic.
      for (int i = 0; i < 2500; i++) begin
         int r;
         r = int'($urandom_range(0, 199));
         if (r < 2) pulse_reset();
         else if (r < 8) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                              3'($urandom()), 1'($urandom_range(0, 1)));
         else step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 3'b000, 1'b0);
      end
      idle(2);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      check("drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
